debounce_pulse_multi: RTL
=========================

// Module: debounce_pulse_multi
// PURPOSE
//  Per-channel debouncer plus single-pulse generator for NCH push-button or
//  switch inputs.
//  - Each channel: 2-flop synchroniser, consecutive-sample stability counter,
//    registered debounced level, one-cycle edge pulse.
//  - Sits between raw board inputs and control FSMs in the clk_200H domain.
//  - Also provides a combined any-channel pulse for wake/step logic.
// PARAMETERS
//  NCH      2  number of independent input channels (>=1)
//  STABLE_N 3  consecutive differing samples needed to accept a change (>=1)
//  EDGE     0  pulse on: 0 = rising (press), 1 = falling (release), 2 = both
//  REP_DLY  50 sample ticks held high before first auto-repeat pulse (macro only)
//  REP_PER  10 sample ticks between subsequent auto-repeat pulses (macro only)
// PORTS
//  clk_200H   in   1    system clock, all state on rising edge
//  rst_n      in   1    asynchronous reset, active low; clears all state
//  sample_en  in   1    sample strobe; stability/repeat counters advance only when 1
//  btn_in     in   NCH  raw asynchronous inputs
//  btn_level  out  NCH  debounced level per channel
//  btn_pulse  out  NCH  one-cycle pulse per channel on a qualifying edge
//  any_pulse  out  1    registered OR of the next-state btn_pulse, same cycle
// BEHAVIOUR
//  Reset:
//  - sync flops, counters, btn_level, btn_pulse and any_pulse all 0.
//  - Release needs no sample_en.
//  Synchroniser:
//  - Two flops per channel, clocked every cycle regardless of sample_en.
//  - s = second-flop output.
//  Stability counter, per channel, width $clog2(STABLE_N+1):
//  - Updates only on cycles with sample_en=1.
//  - s == btn_level: cnt <= 0.
//  - s != btn_level and cnt < STABLE_N-1: cnt <= cnt+1.
//  - s != btn_level and cnt == STABLE_N-1: btn_level <= s, cnt <= 0.
//  - Any single agreeing sample restarts the count, so a glitch shorter
//    than STABLE_N samples never changes btn_level.
//  Pulse:
//  - btn_pulse[i] is registered and high exactly one cycle.
//  - It asserts in the same cycle btn_level[i] first shows the new value,
//    if the edge matches EDGE.
//  - EDGE outside 0..2 behaves as 0.
//  any_pulse:
//  - Registered alongside btn_pulse, from the same next-state values.
//  - High exactly in the cycles where any btn_pulse bit is high.
//  - Simultaneous events on several channels still give one any_pulse cycle.
//  Latency, sample_en tied 1:
//  - Input change ahead of edge 0 -> btn_level/btn_pulse update after edge
//    STABLE_N+1, i.e. STABLE_N+2 edges.
//  - With a strobe, latency is 2 clocks plus STABLE_N strobed samples.
//  Wrap/overflow: counters saturate by construction and never wrap.
//  Reset mid-operation:
//  - Immediate clear.
//  - An input held high through reset is re-qualified after release:
//    one new rising pulse after STABLE_N+2 edges.
// CONFIGURATION
//  Macro DEBOUNCE_AUTOREPEAT_EN defined:
//  - Per-channel repeat counter; starts at 0 when btn_level rises.
//  - Counts only on sample_en=1 while btn_level=1.
//  - Extra btn_pulse when it reaches REP_DLY, then every REP_PER ticks after.
//  - Falling btn_level clears the counter.
//  - Repeat pulses only when EDGE is 0 or 2.
//  - A repeat pulse coinciding with an edge pulse merges into one cycle.
//  Macro undefined:
//  - No repeat logic synthesised; REP_DLY and REP_PER ignored.
// TESTING
//  1 Reset: rst_n=0 with btn_in=all 1s -> all outputs 0.
//    Release, sample_en=1, STABLE_N=3 -> btn_level/btn_pulse rise after
//    edge 4; pulse lasts 1 cycle.
//  2 Glitch: btn_in[0] high for 2 samples, then low (STABLE_N=3)
//    -> btn_level[0] stays 0; no pulse.
//  3 Strobe: sample_en high 1 cycle in 4, btn_in[1] held high -> level
//    changes on the 3rd strobed sample after sync; no change between strobes.
//  4 Multi/edge: EDGE=2, ch0 and ch1 rise together -> both pulses in the
//    same cycle; one any_pulse cycle; release -> second pulse pair.
//  5 Reset mid-count: assert rst_n after 2 of 3 samples -> all 0; count
//    restarts from 0 after release.
//  6 Macro on, REP_DLY=5, REP_PER=2, hold high -> pulses at qualify,
//    +5 ticks, then every 2 ticks; none after release.

Source files
------------

// File: rtl/debounce_pulse_multi_if.sv
// Button bundle between raw board inputs and the debouncer: strobe and raw
// inputs toward the debouncer, debounced levels and pulses back.
interface debounce_pulse_multi_if #(
    parameter int NCH = 2
);
    logic           sample_en;
    logic [NCH-1:0] btn_in;
    logic [NCH-1:0] btn_level;
    logic [NCH-1:0] btn_pulse;
    logic           any_pulse;

    modport master (
        output sample_en, btn_in,
        input  btn_level, btn_pulse, any_pulse
    );

    modport slave (
        input  sample_en, btn_in,
        output btn_level, btn_pulse, any_pulse
    );
endinterface

// File: rtl/debounce_pulse_multi.sv
// Per-channel debouncer with single-cycle edge pulses and a combined any_pulse.
// Defining DEBOUNCE_AUTOREPEAT_EN adds auto-repeat pulses on held buttons.
module debounce_pulse_multi #(
    parameter int NCH      = 2,
    parameter int STABLE_N = 3,
    parameter int EDGE     = 0,
    parameter int REP_DLY  = 50,
    parameter int REP_PER  = 10
) (
    input  logic                  clk_200H,
    input  logic                  rst_n,
    debounce_pulse_multi_if.slave bus
);
    localparam int CW = $clog2(STABLE_N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);
    // Any EDGE value other than 1 or 2 falls back to rising-only.
    localparam logic [NCH-1:0] RISE_MASK = (EDGE != 1) ? '1 : '0;
    localparam logic [NCH-1:0] FALL_MASK = (EDGE == 1 || EDGE == 2) ? '1 : '0;

    logic [NCH-1:0] sync_p0;
    logic [NCH-1:0] sync_p1;
    logic [CW-1:0]  cnt_p2 [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [NCH-1:0] level_p2;
    logic [NCH-1:0] level_d;
    logic [NCH-1:0] pulse_p2;
    logic [NCH-1:0] pulse_d;
    logic [NCH-1:0] rep_hit;
    logic           any_p2;

    // Stage 0/1: two-flop synchroniser, clocked every cycle.
    always_ff @(posedge clk_200H or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.btn_in;
            sync_p1 <= sync_p0;
        end
    end

    always_comb begin
        level_d = level_p2;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_p2[i];
            if (bus.sample_en) begin
                if (sync_p1[i] == level_p2[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    level_d[i] = sync_p1[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_p2[i] + CW'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = $clog2(REP_DLY + REP_PER + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REP_DLY);
    localparam logic [RW-1:0] REP_WRAP  = RW'(REP_DLY + REP_PER);

    logic [RW-1:0] rep_p2 [NCH];
    logic [RW-1:0] rep_d  [NCH];

    // Counter runs REP_DLY..REP_DLY+REP_PER-1 after the first repeat, so it never overflows.
    always_comb begin
        logic [RW-1:0] rep_inc;
        rep_inc = '0;
        rep_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            rep_d[i] = rep_p2[i];
            rep_inc  = rep_p2[i] + RW'(1);
            if (level_d[i] != level_p2[i]) begin
                rep_d[i] = '0;
            end else if (level_p2[i] && bus.sample_en) begin
                rep_d[i]   = (rep_inc == REP_WRAP) ? REP_FIRST : rep_inc;
                rep_hit[i] = RISE_MASK[i] && (rep_d[i] == REP_FIRST);
            end
        end
    end

    always_ff @(posedge clk_200H or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) rep_p2[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) rep_p2[i] <= rep_d[i];
        end
    end
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REP_DLY, REP_PER};
    assign rep_hit        = '0;
`endif

    assign pulse_d = (RISE_MASK &  level_d & ~level_p2)
                   | (FALL_MASK & ~level_d &  level_p2)
                   | rep_hit;

    // Stage 2: qualified level, stability counters and registered pulses.
    always_ff @(posedge clk_200H or negedge rst_n) begin
        if (!rst_n) begin
            level_p2 <= '0;
            pulse_p2 <= '0;
            any_p2   <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt_p2[i] <= '0;
        end else begin
            level_p2 <= level_d;
            pulse_p2 <= pulse_d;
            any_p2   <= |pulse_d;
            for (int i = 0; i < NCH; i++) cnt_p2[i] <= cnt_d[i];
        end
    end

    assign bus.btn_level = level_p2;
    assign bus.btn_pulse = pulse_p2;
    assign bus.any_pulse = any_p2;
endmodule
